shift_register_ctrl: RTL and testbench
======================================

Name: shift_register_ctrl

Overview:
Sequencer that owns the 8-bit Shift_Register datapath and drives its i/s/r inputs from a command interface.
Supports parallel load, serialize (byte to bit stream) and deserialize (bit stream to byte), each over 1..8 bits, left or right.
Sits between a host command port (valid/ready) and the Shift_Register instance, and reads back the register's o bus.
One response is returned per command.

Parameters:
WIDTH, 8, data width of the shift register and of the command/response data.
CNT_W, 4, width of cmd_len and the internal bit counter; must hold the value WIDTH.
FILL_BIT, 1'b0, serial fill bit driven on sr_r during serialize.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command; high only in IDLE.
cmd_op  in  2  00 load, 01 serialize, 10 deserialize, 11 reserved (NOP).
cmd_dir  in  1  0 shift right, 1 shift left.
cmd_len  in  CNT_W  bits to shift; 0 or any value >WIDTH means WIDTH.
cmd_data  in  WIDTH  load/serialize data.
sr_i  out  WIDTH  to Shift_Register i.
sr_s  out  2  to Shift_Register s: 00 hold, 01 right, 10 left, 11 load.
sr_r  out  1  to Shift_Register r (serial in).
sr_o  in  WIDTH  from Shift_Register o.
ser_in  in  1  serial input bit for deserialize.
ser_out  out  1  serial output bit.
ser_out_valid  out  1  ser_out is meaningful this cycle.
rsp_valid  out  1  response present.
rsp_ready  in  1  host accepts response.
rsp_data  out  WIDTH  sr_o snapshot at completion.

Behaviour:
- Shift_Register contract (datapath side):
  - right shift: o <= {r, o[WIDTH-1:1]}.
  - left shift: o <= {o[WIDTH-2:0], r}.
  - load: o <= i.
  - All of the above update on the clk edge.
- Reset (reset=0, async): state=IDLE, counter=0, latched command cleared.
  - Output values during reset: sr_s=00, sr_i=0, sr_r=0, ser_out=0, ser_out_valid=0, rsp_valid=0, rsp_data=0, cmd_ready=0.
  - cmd_ready rises in the first cycle after reset deasserts.
- Reset mid-operation aborts the command: no response is produced and sr_s returns to 00 immediately.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, sr_s=00.
  - On cmd_valid&&cmd_ready, latch op/dir/len/data and transition:
    - op 00, 01, 10 -> LOAD.
    - op 11 -> DONE (NOP; register untouched).
- LOAD (1 cycle):
  - sr_s=11.
  - sr_i = cmd_data for op 00/01; sr_i = 0 for op 10 (clear before capture).
  - Next state: op 00 -> DONE; op 01/10 -> SHIFT with counter=effective len.
- SHIFT (len cycles):
  - sr_s = 01 if dir=0, 10 if dir=1.
  - Counter decrements each cycle; on the cycle the counter equals 1, next state is DONE.
  - Serialize:
    - sr_r=FILL_BIT, ser_out_valid=1.
    - ser_out = sr_o[0] when dir=0, sr_o[WIDTH-1] when dir=1 (the bit leaving on this edge).
  - Deserialize:
    - sr_r=ser_in (sampled into the register on this edge), ser_out_valid=0.
- DONE:
  - sr_s=00 (register held).
  - rsp_valid=1, rsp_data=sr_o (registered in DONE and stable while rsp_valid is high).
  - On rsp_ready go to IDLE. With rsp_ready low, DONE holds indefinitely.
- Latency from accept edge to first rsp_valid:
  - load: 2 cycles.
  - serialize/deserialize: len+2 cycles.
  - NOP: 1 cycle.
- cmd_valid outside IDLE is ignored; no queueing.
- ser_out=0 whenever ser_out_valid=0.
- Back-to-back commands: IDLE is mandatory for at least one cycle between responses.

Decomposition:
- Package shift_ctrl_pkg holds:
  - op encodings (OP_LOAD, OP_SER, OP_DES, OP_NOP).
  - Shift_Register mode constants (S_HOLD=00, S_RIGHT=01, S_LEFT=10, S_LOAD=11).
  - the FSM state enum.
- Sub-module shift_bit_counter (CNT_W down-counter):
  - load with len clamp (0 or >WIDTH -> WIDTH).
  - dec enable.
  - last flag.

Test Plan:
- Serialize 8'b10110011, dir=0, len=8 -> ser_out over 8 valid cycles = 1,1,0,0,1,1,0,1; rsp_data=8'h00; rsp_valid 10 cycles after accept.
- Serialize 8'b10110011, dir=1, len=0 (treated as 8) -> ser_out = 1,0,1,1,0,0,1,1; rsp_data=8'h00.
- Serialize 8'b10110011, dir=0, len=3 -> ser_out = 1,1,0; rsp_data=8'b00010110; rsp_valid 5 cycles after accept.
- Deserialize, dir=1, len=8, ser_in = 1,0,1,0,0,1,0,1 on successive SHIFT cycles -> rsp_data=8'hA5; ser_out_valid stays 0.
- Load 8'h3C with rsp_ready held low 5 cycles -> rsp_valid and rsp_data=8'h3C stable, sr_s=00, cmd_ready=0; cmd_valid pulses during the stall are ignored.
- Assert reset low during the 4th SHIFT cycle of a serialize -> sr_s=00, rsp_valid=0, ser_out_valid=0 immediately; after release cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift register sequencer: command opcodes,
// Shift_Register mode selects and the controller FSM states.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SER  = 2'b01,
        OP_DES  = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Down-counter for the number of shift cycles; a requested length of 0 or
// anything beyond WIDTH is treated as a full WIDTH-bit shift.
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_len;

    always_comb begin
        eff_len = len;
        if (len == '0 || len > CNT_W'(WIDTH)) begin
            eff_len = CNT_W'(WIDTH);
        end
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = eff_len;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_register_ctrl.sv
// Command-driven sequencer for an external 8-bit Shift_Register: parallel
// load, serialize and deserialize, one response per accepted command.
module shift_register_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   CNT_W    = 4,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] sr_i,
    output logic [1:0]       sr_s,
    output logic             sr_r,
    input  logic [WIDTH-1:0] sr_o,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] data_q, data_d;
    // Keeps cmd_ready low while reset is asserted even though the state is IDLE.
    logic             alive_q, alive_d;
    logic             cnt_load, cnt_dec, cnt_last;

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .len   (len_q),
        .dec   (cnt_dec),
        .last  (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        dir_d         = dir_q;
        len_d         = len_q;
        data_d        = data_q;
        alive_d       = 1'b1;
        cmd_ready     = 1'b0;
        sr_s          = S_HOLD;
        sr_i          = '0;
        sr_r          = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = alive_q;
                if (cmd_valid && alive_q) begin
                    op_d    = op_e'(cmd_op);
                    dir_d   = cmd_dir;
                    len_d   = cmd_len;
                    data_d  = cmd_data;
                    state_d = (op_e'(cmd_op) == OP_NOP) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_s     = S_LOAD;
                // Deserialize starts from a cleared register.
                sr_i     = (op_q == OP_DES) ? '0 : data_q;
                cnt_load = 1'b1;
                state_d  = (op_q == OP_LOAD) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_s    = dir_q ? S_LEFT : S_RIGHT;
                cnt_dec = 1'b1;
                if (op_q == OP_SER) begin
                    sr_r          = FILL_BIT;
                    ser_out_valid = 1'b1;
                    ser_out       = dir_q ? sr_o[WIDTH-1] : sr_o[0];
                end else begin
                    sr_r = ser_in;
                end
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The register is held here, so sr_o is stable for the whole response.
                rsp_valid = 1'b1;
                rsp_data  = sr_o;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            dir_q   <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            alive_q <= alive_d;
        end
    end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed and randomized checks of shift_register_ctrl against an arithmetic
// model of each command, with a behavioural Shift_Register attached.
module tb_shift_register_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] sr_i;
    logic [1:0] sr_s;
    logic       sr_r;
    logic [7:0] sr_o = 8'h00;
    logic       ser_in = 1'b0;
    logic       ser_out;
    logic       ser_out_valid;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_reg = 8'h00;

    always #5 clk = ~clk;

    // Behavioural Shift_Register datapath.
    always @(posedge clk) begin
        case (sr_s)
            2'b01:   sr_o <= {sr_r, sr_o[7:1]};
            2'b10:   sr_o <= {sr_o[6:0], sr_r};
            2'b11:   sr_o <= sr_i;
            default: sr_o <= sr_o;
        endcase
    end

    shift_register_ctrl #(
        .WIDTH    (8),
        .CNT_W    (4),
        .FILL_BIT (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_dir       (cmd_dir),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .sr_i          (sr_i),
        .sr_s          (sr_s),
        .sr_r          (sr_r),
        .sr_o          (sr_o),
        .ser_in        (ser_in),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one command. des holds deserialize input bits in time order (bit k
    // is the k-th shift). abort_c > 0 asserts reset in that cycle after accept.
    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] len,
                           input logic [7:0] data, input logic [7:0] des,
                           input int stall, input int abort_c);
        int         n;
        int         lat;
        int         nexp;
        int         got_lat;
        logic [7:0] fin;
        logic       got[$];

        n    = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
        fin  = 8'h00;
        nexp = 0;
        case (op)
            2'd0: begin lat = 2; fin = data; end
            2'd1: begin
                lat  = n + 2;
                nexp = n;
                fin  = dir ? (data << n) : (data >> n);
            end
            2'd2: begin
                lat = n + 2;
                for (int k = 0; k < n; k++) begin
                    if (des[k]) fin[dir ? (n - 1 - k) : (8 - n + k)] = 1'b1;
                end
            end
            default: begin lat = 1; fin = exp_reg; end
        endcase

        @(negedge clk);
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk);

        got_lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ser_in    = (c >= 2 && c <= n + 1) ? des[c-2] : 1'b0;
            if (abort_c != 0 && c == abort_c) begin
                reset = 1'b0;
                #1;
                check("abort_sr_s", 32'(sr_s), 32'd0);
                check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
                check("abort_ser_valid", 32'(ser_out_valid), 32'd0);
                check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
                exp_reg = dir ? (data << (c - 2)) : (data >> (c - 2));
                repeat (2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("post_abort_ready", 32'(cmd_ready), 32'd1);
                for (int k = 0; k < 4; k++) begin
                    check("no_stale_rsp", 32'(rsp_valid), 32'd0);
                    @(negedge clk);
                end
                $display("cmd op=%0d dir=%0d len=%0d data=%02h aborted in cycle %0d", op, dir, len, data, c);
                return;
            end
            if (ser_out_valid) got.push_back(ser_out);
            else check("ser_out_zero", 32'(ser_out), 32'd0);
            if (rsp_valid) begin
                got_lat = c;
                break;
            end
        end

        if (got_lat == 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(got_lat), 32'(lat));
            check("ser_count", 32'(got.size()), 32'(nexp));
            for (int k = 0; k < got.size() && k < nexp; k++) begin
                check("ser_bit", 32'(got[k]), 32'(dir ? data[7-k] : data[k]));
            end
            check("rsp_data", 32'(rsp_data), 32'(fin));
            check("done_sr_s", 32'(sr_s), 32'd0);
            check("done_cmd_ready", 32'(cmd_ready), 32'd0);
            for (int s = 0; s < stall; s++) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                cmd_data  = 8'hFF;
                @(negedge clk);
                check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                check("stall_rsp_data", 32'(rsp_data), 32'(fin));
                check("stall_sr_s", 32'(sr_s), 32'd0);
                check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            end
        end
        exp_reg   = fin;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("cmd op=%0d dir=%0d len=%0d data=%02h des=%02h rsp=%02h lat=%0d bits=%0d",
                 op, dir, len, data, des, fin, got_lat, got.size());
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_sr_s", 32'(sr_s), 32'd0);
        check("rst_sr_i", 32'(sr_i), 32'd0);
        check("rst_sr_r", 32'(sr_r), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_ser_valid", 32'(ser_out_valid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("first_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'd1, 1'b0, 4'd8, 8'b10110011, 8'h00, 0, 0);
        run_cmd(2'd1, 1'b1, 4'd0, 8'b10110011, 8'h00, 0, 0);
        run_cmd(2'd1, 1'b0, 4'd3, 8'b10110011, 8'h00, 0, 0);
        run_cmd(2'd2, 1'b1, 4'd8, 8'h00, 8'b10100101, 0, 0);
        run_cmd(2'd0, 1'b0, 4'd0, 8'h3C, 8'h00, 5, 0);
        run_cmd(2'd3, 1'b0, 4'd0, 8'h00, 8'h00, 0, 0);
        run_cmd(2'd2, 1'b0, 4'd1, 8'h00, 8'h01, 0, 0);
        run_cmd(2'd1, 1'b1, 4'd15, 8'hC3, 8'h00, 1, 0);
        run_cmd(2'd1, 1'b0, 4'd8, 8'b10110011, 8'h00, 0, 5);
        run_cmd(2'd3, 1'b1, 4'd2, 8'h55, 8'h00, 0, 0);

        for (int t = 0; t < 24; t++) begin
            run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
